// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command-side issue controller.
//   alu_op_e       : ALU operation codes (110/111 are unsupported)
//   cond_e         : branch condition selector encodings
//   issue_state_e  : issue FSM states
//   CMP_LT         : value the ALU returns from CMP when A < B
package alu_pkg;

    typedef enum logic [2:0] {
        OP_SUB  = 3'b000,
        OP_ADD  = 3'b001,
        OP_LSL  = 3'b010,
        OP_NEG  = 3'b011,
        OP_PASS = 3'b100,
        OP_CMP  = 3'b101
    } alu_op_e;

    typedef enum logic [1:0] {
        COND_ALWAYS = 2'b00,
        COND_EQ     = 2'b01,
        COND_LT     = 2'b10,
        COND_GT     = 2'b11
    } cond_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_HOLD = 2'b10
    } issue_state_e;

    localparam int CMP_LT = 2;

endpackage

// File: rtl/cond_eval.sv
// Branch condition evaluation against the architectural flag register.
// Ports:
//   cond_sel  in  2  condition selector (cond_e encoding)
//   flag_n    in  1  architectural N flag
//   flag_z    in  1  architectural Z flag
//   cond_true out 1  selected condition holds
module cond_eval
    import alu_pkg::*;
(
    input  logic [1:0] cond_sel,
    input  logic       flag_n,
    input  logic       flag_z,
    output logic       cond_true
);

    always_comb begin
        cond_true = 1'b1;
        case (cond_e'(cond_sel))
            COND_ALWAYS: cond_true = 1'b1;
            COND_EQ:     cond_true = flag_z;
            COND_LT:     cond_true = flag_n;
            COND_GT:     cond_true = !flag_n && !flag_z;
            default:     cond_true = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Command-side initiator for the 16-bit ALU. Registers accepted commands,
// drives the ALU from those registers, captures result/flags into a held
// response, and owns the architectural N/Z flag register.
// Ports:
//   clk, rst                      clock, async active-high reset
//   cmd_valid/ready/op/a/b/setflags  command channel
//   alu_op, alu_src_a, alu_src_b  registered ALU inputs
//   alu_result, alu_flag_n/z      ALU outputs
//   rsp_valid/ready/data/flag_n/flag_z/err  response channel
//   flag_n_q, flag_z_q            architectural flags
//   cond_sel, cond_true           branch condition evaluation
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no command in flight, ready for a command
// EXEC  | ALU driven from operand registers, result captured at next edge
// HOLD  | response presented, waiting for rsp_ready
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int OPW   = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [OPW-1:0]   cmd_op,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic             cmd_setflags,
    output logic [OPW-1:0]   alu_op,
    output logic [WIDTH-1:0] alu_src_a,
    output logic [WIDTH-1:0] alu_src_b,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_flag_n,
    input  logic             alu_flag_z,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_flag_n,
    output logic             rsp_flag_z,
    output logic             rsp_err,
    output logic             flag_n_q,
    output logic             flag_z_q,
    input  logic [1:0]       cond_sel,
    output logic             cond_true
);

    issue_state_e     state_q;
    logic [OPW-1:0]   op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             setflags_q;
    logic             rsp_valid_q;
    logic [WIDTH-1:0] rsp_data_q;
    logic             rsp_flag_n_q;
    logic             rsp_flag_z_q;
    logic             rsp_err_q;
    logic             op_ok;
    logic             cmd_acc;

    // Unsupported ops are masked here so nothing the ALU drives for them
    // (including X) reaches the response or the flag register.
    assign op_ok = (op_q <= OPW'(OP_CMP));

    // Gated by rst so no handshake can be seen while reset is held.
    assign cmd_ready = !rst && ((state_q == ST_IDLE) ||
                                ((state_q == ST_HOLD) && rsp_ready));
    assign cmd_acc   = cmd_valid && cmd_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            setflags_q   <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            rsp_flag_n_q <= 1'b0;
            rsp_flag_z_q <= 1'b0;
            rsp_err_q    <= 1'b0;
            flag_n_q     <= 1'b0;
            flag_z_q     <= 1'b0;
        end else begin
            if (cmd_acc) begin
                op_q       <= cmd_op;
                a_q        <= cmd_a;
                b_q        <= cmd_b;
                setflags_q <= cmd_setflags;
            end
            case (state_q)
                ST_IDLE: begin
                    if (cmd_acc) state_q <= ST_EXEC;
                end
                ST_EXEC: begin
                    rsp_valid_q  <= 1'b1;
                    rsp_err_q    <= !op_ok;
                    rsp_data_q   <= op_ok ? alu_result : '0;
                    rsp_flag_n_q <= op_ok && alu_flag_n;
                    rsp_flag_z_q <= op_ok && alu_flag_z;
                    if (setflags_q && op_ok) begin
                        flag_n_q <= alu_flag_n;
                        flag_z_q <= alu_flag_z;
                    end
                    state_q <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= cmd_valid ? ST_EXEC : ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign alu_op     = op_q;
    assign alu_src_a  = a_q;
    assign alu_src_b  = b_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_flag_n = rsp_flag_n_q;
    assign rsp_flag_z = rsp_flag_z_q;
    assign rsp_err    = rsp_err_q;

    cond_eval u_cond_eval (
        .cond_sel  (cond_sel),
        .flag_n    (flag_n_q),
        .flag_z    (flag_z_q),
        .cond_true (cond_true)
    );

endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_op = '0;
    logic [15:0] cmd_a = '0;
    logic [15:0] cmd_b = '0;
    logic        cmd_setflags = 1'b0;
    logic [2:0]  alu_op;
    logic [15:0] alu_src_a, alu_src_b, alu_result;
    logic        alu_flag_n, alu_flag_z;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [15:0] rsp_data;
    logic        rsp_flag_n, rsp_flag_z, rsp_err;
    logic        flag_n_q, flag_z_q;
    logic [1:0]  cond_sel = 2'b00;
    logic        cond_true;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] data;
        logic        n, z, err, fn, fz;
        int          acc;
    } exp_t;

    exp_t sb[$];
    logic mdl_n = 1'b0, mdl_z = 1'b0;
    logic prev_v = 1'b0;

    alu_issue_ctrl #(.WIDTH(16), .OPW(3)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_setflags(cmd_setflags),
        .alu_op(alu_op), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_result(alu_result), .alu_flag_n(alu_flag_n), .alu_flag_z(alu_flag_z),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_flag_n(rsp_flag_n), .rsp_flag_z(rsp_flag_z), .rsp_err(rsp_err),
        .flag_n_q(flag_n_q), .flag_z_q(flag_z_q),
        .cond_sel(cond_sel), .cond_true(cond_true)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Reference ALU: {n, z, result}. Unsupported ops drive junk so that
    // masking in the DUT is observable.
    function automatic logic [17:0] alu_f(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [15:0] r;
        logic        n;
        case (op)
            3'b000:  r = a - b;
            3'b001:  r = a + b;
            3'b010:  r = a << b[3:0];
            3'b011:  r = -a;
            3'b100:  r = a;
            3'b101:  r = (a < b) ? 16'(CMP_LT) : ((a == b) ? 16'd0 : 16'd1);
            default: return {1'b1, 1'b1, 16'hDEAD};
        endcase
        n = (op == 3'b101) ? (a < b) : r[15];
        return {n, (r == 16'd0), r};
    endfunction

    always_comb {alu_flag_n, alu_flag_z, alu_result} = alu_f(alu_op, alu_src_a, alu_src_b);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Scoreboard monitor: pops on response handshake, pushes on command handshake.
    always @(negedge clk) begin
        if (!rst) begin
            if (rsp_valid && !prev_v) begin
                if (sb.size() == 0) chk("stale_rsp", 32'(rsp_valid), 32'd0);
                else                chk("rsp_latency", 32'(cyc), 32'(sb[0].acc + 1));
            end
            if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("rsp_data",   32'(rsp_data),   32'(e.data));
                    chk("rsp_flag_n", 32'(rsp_flag_n), 32'(e.n));
                    chk("rsp_flag_z", 32'(rsp_flag_z), 32'(e.z));
                    chk("rsp_err",    32'(rsp_err),    32'(e.err));
                    chk("flag_n_q",   32'(flag_n_q),   32'(e.fn));
                    chk("flag_z_q",   32'(flag_z_q),   32'(e.fz));
                    chk("alu_op",     32'(alu_op),     32'(e.op));
                    chk("alu_src_a",  32'(alu_src_a),  32'(e.a));
                end
            end
            if (cmd_valid && cmd_ready) begin
                exp_t e;
                logic [17:0] r;
                e.op  = cmd_op;
                e.a   = cmd_a;
                e.acc = cyc + 1;
                if (cmd_op >= 3'b110) begin
                    e.data = '0; e.n = 1'b0; e.z = 1'b0; e.err = 1'b1;
                end else begin
                    r = alu_f(cmd_op, cmd_a, cmd_b);
                    e.data = r[15:0]; e.n = r[17]; e.z = r[16]; e.err = 1'b0;
                    if (cmd_setflags) begin
                        mdl_n = e.n;
                        mdl_z = e.z;
                    end
                end
                e.fn = mdl_n;
                e.fz = mdl_z;
                sb.push_back(e);
            end
        end
        prev_v = rsp_valid;
    end

    task automatic send(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b, input logic sf);
        logic ok;
        ok = 1'b0;
        cmd_op = op; cmd_a = a; cmd_b = b; cmd_setflags = sf; cmd_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (cmd_ready) begin ok = 1'b1; break; end
        end
        if (!ok) chk("send_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (sb.size() == 0) begin ok = 1'b1; break; end
        end
        if (!ok) chk("drain_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
    endtask

    function automatic logic cond_mdl(input logic [1:0] s, input logic n, input logic z);
        case (s)
            2'b00:   return 1'b1;
            2'b01:   return z;
            2'b10:   return n;
            default: return !n && !z;
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic ok;
        // Reset values
        #12;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_err",   32'(rsp_err),   32'd0);
        chk("rst_flags",     32'({flag_n_q, flag_z_q}), 32'd0);
        chk("rst_alu_a",     32'(alu_src_a), 32'd0);
        for (int s = 0; s < 4; s++) begin
            cond_sel = 2'(s); #1;
            chk("rst_cond", 32'(cond_true), 32'(cond_mdl(2'(s), 1'b0, 1'b0)));
        end
        cond_sel = 2'b00;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;

        // ADD 3+4
        send(3'b001, 16'h0003, 16'h0004, 1'b1);
        wait_idle();

        // CMP 5 vs 9 -> N set, condition checks
        send(3'b101, 16'd5, 16'd9, 1'b1);
        wait_idle();
        cond_sel = 2'b10; #1; chk("cmp_lt", 32'(cond_true), 32'd1);
        cond_sel = 2'b01; #1; chk("cmp_eq", 32'(cond_true), 32'd0);
        cond_sel = 2'b11; #1; chk("cmp_gt", 32'(cond_true), 32'd0);
        cond_sel = 2'b00;

        // SUB 7-7 without setflags: Z in response only
        send(3'b000, 16'd7, 16'd7, 1'b0);
        wait_idle();
        chk("sub_noflag_z", 32'(flag_z_q), 32'd0);

        // Backpressure with a second command waiting
        rsp_ready = 1'b0;
        send(3'b001, 16'h8000, 16'h0001, 1'b1);
        cmd_op = 3'b100; cmd_a = 16'h0000; cmd_b = 16'h0005; cmd_setflags = 1'b1; cmd_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rsp_valid) begin ok = 1'b1; break; end
        end
        if (!ok) chk("hold_rsp_timeout", 32'd0, 32'd1);
        for (int i = 0; i < 3; i++) begin
            chk("hold_cmd_ready", 32'(cmd_ready), 32'd0);
            chk("hold_rsp_data",  32'(rsp_data),  32'h8001);
            chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
            @(negedge clk);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("hold_release_ready", 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        wait_idle();

        // Unsupported op with setflags: flags keep PASS-0 result (N0 Z1)
        send(3'b110, 16'h1234, 16'h0001, 1'b1);
        wait_idle();
        chk("badop_flag_z", 32'(flag_z_q), 32'd1);

        // Random back-to-back traffic
        for (int i = 0; i < 12; i++)
            send(3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
        wait_idle();
        for (int s = 0; s < 4; s++) begin
            cond_sel = 2'(s); #1;
            chk("rand_cond", 32'(cond_true), 32'(cond_mdl(2'(s), mdl_n, mdl_z)));
        end
        cond_sel = 2'b00;

        // Reset during EXEC
        send(3'b101, 16'd1, 16'd2, 1'b1);
        wait_idle();
        chk("pre_rst_flag_n", 32'(flag_n_q), 32'd1);
        send(3'b001, 16'd1, 16'd1, 1'b1);
        rst = 1'b1;
        #1;
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_flags",     32'({flag_n_q, flag_z_q}), 32'd0);
        chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd0);
        sb.delete();
        mdl_n = 1'b0; mdl_z = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("after_rst_ready", 32'(cmd_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("no_stale_rsp", 32'(rsp_valid), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
